// File: rtl/iguana_hyper_cfg_init.sv
// Boot-time Hyperbus register initialiser: replays a fixed table of writes,
// then passes the upstream register bus straight through.
module iguana_hyper_cfg_init #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumInit   = 4,
  parameter logic [(NumInit>0?NumInit:1)-1:0][AddrWidth-1:0] InitAddr = '0,
  parameter logic [(NumInit>0?NumInit:1)-1:0][DataWidth-1:0] InitData = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reinit_i,
  input  logic                   slv_valid_i,
  input  logic                   slv_write_i,
  input  logic [AddrWidth-1:0]   slv_addr_i,
  input  logic [DataWidth-1:0]   slv_wdata_i,
  input  logic [DataWidth/8-1:0] slv_wstrb_i,
  output logic                   slv_ready_o,
  output logic [DataWidth-1:0]   slv_rdata_o,
  output logic                   slv_error_o,
  output logic                   mst_valid_o,
  output logic                   mst_write_o,
  output logic [AddrWidth-1:0]   mst_addr_o,
  output logic [DataWidth-1:0]   mst_wdata_o,
  output logic [DataWidth/8-1:0] mst_wstrb_o,
  input  logic                   mst_ready_i,
  input  logic [DataWidth-1:0]   mst_rdata_i,
  input  logic                   mst_error_i,
  output logic                   init_done_o,
  output logic                   init_error_o
);

  localparam int unsigned IdxW = (NumInit > 1) ? $clog2(NumInit) : 1;
  localparam logic [IdxW-1:0] IdxLast =
    IdxW'((NumInit > 0) ? NumInit - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    mst_valid_o = 1'b0;
    mst_write_o = 1'b0;
    mst_addr_o  = '0;
    mst_wdata_o = '0;
    mst_wstrb_o = '0;
    slv_ready_o = 1'b0;
    slv_rdata_o = '0;
    slv_error_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d   = '0;
        state_d = (NumInit > 0) ? INIT : DONE;
      end
      INIT: begin
        mst_valid_o = 1'b1;
        mst_write_o = 1'b1;
        mst_addr_o  = InitAddr[idx_q];
        mst_wdata_o = InitData[idx_q];
        mst_wstrb_o = '1;
        if (mst_ready_i) begin
          if (mst_error_i) err_d = 1'b1;
          if (idx_q == IdxLast) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      DONE: begin
        mst_valid_o = slv_valid_i;
        mst_write_o = slv_write_i;
        mst_addr_o  = slv_addr_i;
        mst_wdata_o = slv_wdata_i;
        mst_wstrb_o = slv_wstrb_i;
        slv_ready_o = mst_ready_i;
        slv_rdata_o = mst_rdata_i;
        slv_error_o = mst_error_i;
        // Only replay between upstream transfers so none is torn.
        if (reinit_i && !slv_valid_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign init_done_o  = (state_q == DONE);
  assign init_error_o = err_q;

endmodule

// File: tb/tb_iguana_hyper_cfg_init.sv
// Directed checks of the init sequencer: table replay, stalls, errors,
// upstream passthrough, reinit, async reset and the empty-table case.
module tb_iguana_hyper_cfg_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // DUT 0: four-entry table
  logic        rst = 1'b1, reinit = 1'b0;
  logic        sv = 1'b0, sw = 1'b0;
  logic [47:0] sa = '0;
  logic [31:0] swd = '0;
  logic [3:0]  sws = '0;
  logic        s_rdy, s_err;
  logic [31:0] s_rd;
  logic        m_val, m_wr;
  logic [47:0] m_addr;
  logic [31:0] m_wd;
  logic [3:0]  m_ws;
  logic        m_rdy = 1'b0, m_err = 1'b0;
  logic [31:0] m_rd = '0;
  logic        done, ierr;

  iguana_hyper_cfg_init #(
    .AddrWidth(48), .DataWidth(32), .NumInit(4),
    .InitAddr({48'h1C, 48'h18, 48'h14, 48'h10}),
    .InitData({32'd4, 32'd3, 32'd2, 32'd1})
  ) dut (
    .clk_i(clk), .rst_i(rst), .reinit_i(reinit),
    .slv_valid_i(sv), .slv_write_i(sw), .slv_addr_i(sa),
    .slv_wdata_i(swd), .slv_wstrb_i(sws),
    .slv_ready_o(s_rdy), .slv_rdata_o(s_rd), .slv_error_o(s_err),
    .mst_valid_o(m_val), .mst_write_o(m_wr), .mst_addr_o(m_addr),
    .mst_wdata_o(m_wd), .mst_wstrb_o(m_ws),
    .mst_ready_i(m_rdy), .mst_rdata_i(m_rd), .mst_error_i(m_err),
    .init_done_o(done), .init_error_o(ierr)
  );

  // DUT 1: empty table
  logic        rst1 = 1'b1, reinit1 = 1'b0;
  logic        sv1 = 1'b0, sw1 = 1'b0;
  logic [47:0] sa1 = '0;
  logic [31:0] swd1 = '0;
  logic [3:0]  sws1 = '0;
  logic        s_rdy1, s_err1;
  logic [31:0] s_rd1;
  logic        m_val1, m_wr1;
  logic [47:0] m_addr1;
  logic [31:0] m_wd1;
  logic [3:0]  m_ws1;
  logic        m_rdy1 = 1'b0, m_err1 = 1'b0;
  logic [31:0] m_rd1 = '0;
  logic        done1, ierr1;

  iguana_hyper_cfg_init #(
    .AddrWidth(48), .DataWidth(32), .NumInit(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst1), .reinit_i(reinit1),
    .slv_valid_i(sv1), .slv_write_i(sw1), .slv_addr_i(sa1),
    .slv_wdata_i(swd1), .slv_wstrb_i(sws1),
    .slv_ready_o(s_rdy1), .slv_rdata_o(s_rd1), .slv_error_o(s_err1),
    .mst_valid_o(m_val1), .mst_write_o(m_wr1), .mst_addr_o(m_addr1),
    .mst_wdata_o(m_wd1), .mst_wstrb_o(m_ws1),
    .mst_ready_i(m_rdy1), .mst_rdata_i(m_rd1), .mst_error_i(m_err1),
    .init_done_o(done1), .init_error_o(ierr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves DUT 0 in its IDLE cycle, 1 ns after an edge.
  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_rdy = 1'b1; m_rd = 32'hFFFF_FFFF; m_err = 1'b1;
    tick();
    assertions++;
    if ({m_val, m_wr, m_addr, m_wd, m_ws} !== '0) begin
      failures++; $display("FAIL reset_mst got %0h want 0", m_addr);
    end
    assertions++;
    if ({s_rdy, s_rd, s_err, done, ierr} !== '0) begin
      failures++; $display("FAIL reset_slv rdy=%0b rd=%0h done=%0b err=%0b want 0",
                           s_rdy, s_rd, done, ierr);
    end
    m_err = 1'b0; m_rd = '0;
  endtask

  task automatic test_init_fast();
    m_rdy = 1'b1;
    restart();
    assertions++;
    if (m_val !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL fast_idle valid=%0b done=%0b want 0 0", m_val, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      assertions++;
      if (m_val !== 1'b1 || m_wr !== 1'b1 || m_addr !== 48'h10 + 48'(4*i) ||
          m_wd !== 32'(i+1) || m_ws !== 4'hF || s_rdy !== 1'b0) begin
        failures++;
        $display("FAIL fast_write%0d got v=%0b a=%0h d=%0h s=%0h r=%0b want 1 %0h %0h f 0",
                 i, m_val, m_addr, m_wd, m_ws, s_rdy, 48'h10 + 48'(4*i), i+1);
      end
    end
    tick();
    assertions++;
    if (done !== 1'b1 || ierr !== 1'b0 || m_val !== 1'b0) begin
      failures++; $display("FAIL fast_done done=%0b err=%0b valid=%0b want 1 0 0",
                           done, ierr, m_val);
    end
  endtask

  task automatic test_slow_error();
    m_rdy = 1'b0; m_err = 1'b0;
    restart();
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 4; w++) begin
        tick();
        m_rdy = 1'b0; m_err = 1'b0;
        assertions++;
        if (m_val !== 1'b1 || m_addr !== 48'h10 + 48'(4*i) || m_wd !== 32'(i+1)) begin
          failures++;
          $display("FAIL slow_hold%0d_%0d got v=%0b a=%0h d=%0h want 1 %0h %0h",
                   i, w, m_val, m_addr, m_wd, 48'h10 + 48'(4*i), i+1);
        end
        if (w == 0 && i >= 2) begin
          assertions++;
          if (ierr !== (i == 3)) begin
            failures++; $display("FAIL slow_err_at%0d got %0b want %0b", i, ierr, i == 3);
          end
        end
        if (w == 3) begin
          m_rdy = 1'b1; m_err = (i == 2);
        end
      end
    end
    tick();
    m_rdy = 1'b0; m_err = 1'b0;
    tick();
    assertions++;
    if (done !== 1'b1 || ierr !== 1'b1) begin
      failures++; $display("FAIL slow_done done=%0b err=%0b want 1 1", done, ierr);
    end
  endtask

  task automatic test_reinit();
    sv = 1'b1; sw = 1'b0; sa = 48'h40; reinit = 1'b1;
    tick();
    assertions++;
    if (done !== 1'b1 || ierr !== 1'b1 || m_val !== 1'b1 || m_addr !== 48'h40) begin
      failures++; $display("FAIL reinit_ignored done=%0b err=%0b v=%0b a=%0h want 1 1 1 40",
                           done, ierr, m_val, m_addr);
    end
    sv = 1'b0;
    tick();
    reinit = 1'b0;
    assertions++;
    if (done !== 1'b0 || ierr !== 1'b0 || m_val !== 1'b0) begin
      failures++; $display("FAIL reinit_idle done=%0b err=%0b v=%0b want 0 0 0",
                           done, ierr, m_val);
    end
    m_rdy = 1'b1;
    tick();
    assertions++;
    if (m_val !== 1'b1 || m_addr !== 48'h10 || m_wd !== 32'd1) begin
      failures++; $display("FAIL reinit_first got v=%0b a=%0h d=%0h want 1 10 1",
                           m_val, m_addr, m_wd);
    end
    tick(); tick(); tick(); tick();
    assertions++;
    if (done !== 1'b1 || ierr !== 1'b0) begin
      failures++; $display("FAIL reinit_done done=%0b err=%0b want 1 0", done, ierr);
    end
  endtask

  task automatic test_pending_read();
    m_rdy = 1'b1; m_rd = 32'hCAFE;
    restart();
    sv = 1'b1; sw = 1'b0; sa = 48'h20; sws = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      assertions++;
      if (s_rdy !== 1'b0 || s_rd !== 32'h0 || m_addr !== 48'h10 + 48'(4*i)) begin
        failures++; $display("FAIL read_stall%0d rdy=%0b rd=%0h a=%0h want 0 0 %0h",
                             i, s_rdy, s_rd, m_addr, 48'h10 + 48'(4*i));
      end
    end
    tick();
    assertions++;
    if (m_addr !== 48'h20 || m_wr !== 1'b0 || m_val !== 1'b1 ||
        s_rdy !== 1'b1 || s_rd !== 32'hCAFE) begin
      failures++; $display("FAIL read_serve a=%0h w=%0b rdy=%0b rd=%0h want 20 0 1 cafe",
                           m_addr, m_wr, s_rdy, s_rd);
    end
    m_err = 1'b1;
    #1;
    assertions++;
    if (s_err !== 1'b1) begin
      failures++; $display("FAIL read_error got %0b want 1", s_err);
    end
    m_err = 1'b0; sv = 1'b0; m_rd = '0;
  endtask

  task automatic test_async_reset();
    m_rdy = 1'b0;
    restart();
    tick();
    m_rdy = 1'b1;
    tick();
    tick();
    m_rdy = 1'b0;
    tick();
    assertions++;
    if (m_addr !== 48'h18) begin
      failures++; $display("FAIL areset_wait got %0h want 18", m_addr);
    end
    #2 rst = 1'b1;
    #1;
    assertions++;
    if ({m_val, m_addr, m_wd, m_ws, s_rdy, done, ierr} !== '0) begin
      failures++; $display("FAIL areset_zero v=%0b a=%0h done=%0b want 0 0 0",
                           m_val, m_addr, done);
    end
    #1 rst = 1'b0;
    tick();
    assertions++;
    if (m_val !== 1'b1 || m_addr !== 48'h10) begin
      failures++; $display("FAIL areset_restart v=%0b a=%0h want 1 10", m_val, m_addr);
    end
  endtask

  task automatic test_zero_init();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    sv1 = 1'b1; sw1 = 1'b1; sa1 = 48'h44; swd1 = 32'h1234; sws1 = 4'h3;
    m_rdy1 = 1'b1; m_rd1 = 32'h55;
    #1;
    assertions++;
    if (done1 !== 1'b0 || m_val1 !== 1'b0 || s_rdy1 !== 1'b0) begin
      failures++; $display("FAIL zero_idle done=%0b v=%0b rdy=%0b want 0 0 0",
                           done1, m_val1, s_rdy1);
    end
    tick();
    assertions++;
    if (done1 !== 1'b1 || m_val1 !== 1'b1 || m_wr1 !== 1'b1 || m_addr1 !== 48'h44 ||
        m_wd1 !== 32'h1234 || m_ws1 !== 4'h3 || s_rdy1 !== 1'b1 || s_rd1 !== 32'h55) begin
      failures++; $display("FAIL zero_pass done=%0b a=%0h d=%0h s=%0h rdy=%0b want 1 44 1234 3 1",
                           done1, m_addr1, m_wd1, m_ws1, s_rdy1);
    end
  endtask

  initial begin
    test_reset();
    test_init_fast();
    test_slow_error();
    test_reinit();
    test_pending_read();
    test_async_reset();
    test_zero_init();
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule
